// File: rtl/decade_count_scheduler_pkg.sv
// rtl/decade_count_scheduler_pkg.sv - shared types, constants and length clamp for the decade scheduler
package decade_count_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int LEN_W = 4;
    localparam logic [LEN_W-1:0] MAX_TICK = 4'd9;

    // A zero-length request still occupies one tick; anything past a decade saturates.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len == '0) begin
            return LEN_W'(1);
        end else if (len > MAX_TICK) begin
            return MAX_TICK;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/decade_count_scheduler_rr_pick.sv
// rtl/decade_count_scheduler_rr_pick.sv - combinational round-robin selector
// Searches upward from ptr+1 with wrap-around; returns one-hot winner and its index.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDW-1:0]     win_idx,
    output logic               win_valid
);

    int w_cand;

    always_comb begin
        winner    = '0;
        win_idx   = '0;
        win_valid = 1'b0;
        w_cand    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = (int'(ptr) + k) % NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!win_valid && (i == w_cand) && req[i]) begin
                    win_valid = 1'b1;
                    winner[i] = 1'b1;
                    win_idx   = IDW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/decade_count_scheduler.sv
// rtl/decade_count_scheduler.sv - round-robin sharing of one mod-10 tick counter among requesters
module decade_count_scheduler
    import decade_count_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [4*NUM_REQ-1:0]   req_len,
    input  logic                   enable,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic [3:0]             count,
    output logic                   done,
    output logic [IDW-1:0]         done_id
);

    state_t               r_state,   w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant,   w_grant_nxt;
    logic                 r_busy,    w_busy_nxt;
    logic [LEN_W-1:0]     r_count,   w_count_nxt;
    logic [LEN_W-1:0]     r_len,     w_len_nxt;
    logic                 r_done,    w_done_nxt;
    logic [IDW-1:0]       r_done_id, w_done_id_nxt;
    logic [IDW-1:0]       r_ptr,     w_ptr_nxt;
    logic [IDW-1:0]       r_idx,     w_idx_nxt;

    logic [NUM_REQ-1:0]   w_win_onehot;
    logic [IDW-1:0]       w_win_idx;
    logic                 w_win_valid;
    logic [LEN_W-1:0]     w_win_len;
    logic                 w_owner_req;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_pick (
        .req       (req),
        .ptr       (r_ptr),
        .winner    (w_win_onehot),
        .win_idx   (w_win_idx),
        .win_valid (w_win_valid)
    );

    always_comb begin
        w_win_len = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_onehot[i]) begin
                w_win_len = req_len[LEN_W*i +: LEN_W];
            end
        end
    end

    assign w_owner_req = |(req & r_grant);

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_busy_nxt    = r_busy;
        w_count_nxt   = r_count;
        w_len_nxt     = r_len;
        w_done_nxt    = 1'b0;
        w_done_id_nxt = r_done_id;
        w_ptr_nxt     = r_ptr;
        w_idx_nxt     = r_idx;
        case (r_state)
            ST_IDLE: begin
                w_grant_nxt = '0;
                w_count_nxt = '0;
                w_busy_nxt  = 1'b0;
                if (w_win_valid) begin
                    w_state_nxt = ST_RUN;
                    w_grant_nxt = w_win_onehot;
                    w_busy_nxt  = 1'b1;
                    w_ptr_nxt   = w_win_idx;
                    w_idx_nxt   = w_win_idx;
                    w_len_nxt   = clamp_len(w_win_len);
                end
            end
            ST_RUN: begin
                // Owner withdrawal wins over a tick landing in the same cycle.
                if (!w_owner_req) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_count_nxt = '0;
                    w_busy_nxt  = 1'b0;
                end else if (enable) begin
                    if (r_count == r_len - LEN_W'(1)) begin
                        w_state_nxt   = ST_DONE;
                        w_grant_nxt   = '0;
                        w_count_nxt   = '0;
                        w_done_nxt    = 1'b1;
                        w_done_id_nxt = r_idx;
                    end else begin
                        w_count_nxt = r_count + LEN_W'(1);
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
                w_grant_nxt = '0;
                w_count_nxt = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_count_nxt = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_count   <= '0;
            r_len     <= LEN_W'(1);
            r_done    <= 1'b0;
            r_done_id <= '0;
            r_ptr     <= IDW'(NUM_REQ - 1);
            r_idx     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_busy    <= w_busy_nxt;
            r_count   <= w_count_nxt;
            r_len     <= w_len_nxt;
            r_done    <= w_done_nxt;
            r_done_id <= w_done_id_nxt;
            r_ptr     <= w_ptr_nxt;
            r_idx     <= w_idx_nxt;
        end
    end

    assign grant   = r_grant;
    assign busy    = r_busy;
    assign count   = r_count;
    assign done    = r_done;
    assign done_id = r_done_id;

endmodule

// File: tb/tb_decade_count_scheduler.sv
// tb/tb_decade_count_scheduler.sv - directed and randomized bench with a transaction-level reference model
module tb_decade_count_scheduler;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [4*N-1:0] req_len;
    logic           enable;
    logic [N-1:0]   grant;
    logic           busy;
    logic [3:0]     count;
    logic           done;
    logic [IDW-1:0] done_id;

    int checks   = 0;
    int failures = 0;

    // reference model: who owns the counter, how many ticks elapsed, pending done cycle
    int m_owner;
    int m_ticks;
    int m_len;
    int m_ptr;
    int m_done_id;
    bit m_done;

    decade_count_scheduler #(
        .NUM_REQ (N),
        .IDW     (IDW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .req_len (req_len),
        .enable  (enable),
        .grant   (grant),
        .busy    (busy),
        .count   (count),
        .done    (done),
        .done_id (done_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int clampi(input int l);
        if (l == 0) return 1;
        if (l > 9) return 9;
        return l;
    endfunction

    task automatic model_reset();
        m_owner   = -1;
        m_ticks   = 0;
        m_len     = 1;
        m_ptr     = N - 1;
        m_done    = 1'b0;
        m_done_id = 0;
    endtask

    task automatic model_edge();
        logic [31:0] rv;
        logic [31:0] lv;
        int c;
        bit found;
        rv = 32'(req);
        lv = 32'(req_len);
        if (m_done) begin
            m_done = 1'b0;
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                c = (m_ptr + k) % N;
                if (!found && ((rv >> c) & 32'd1) != 0) begin
                    found   = 1'b1;
                    m_owner = c;
                    m_ptr   = c;
                    m_ticks = 0;
                    m_len   = clampi(int'((lv >> (4 * c)) & 32'd15));
                end
            end
        end else if (((rv >> m_owner) & 32'd1) == 0) begin
            m_owner = -1;
            m_ticks = 0;
        end else if (enable) begin
            m_ticks++;
            if (m_ticks == m_len) begin
                m_done    = 1'b1;
                m_done_id = m_owner;
                m_owner   = -1;
                m_ticks   = 0;
            end
        end
    endtask

    task automatic check_outputs();
        logic [31:0] eg;
        eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        chk("grant", 32'(grant), eg);
        chk("busy", 32'(busy), (m_owner >= 0 || m_done) ? 32'd1 : 32'd0);
        chk("count", 32'(count), 32'(m_ticks));
        chk("done", 32'(done), 32'(m_done));
        if (m_done) chk("done_id", 32'(done_id), 32'(m_done_id));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    // entered at a negedge; asserts reset between edges and checks outputs before any clock
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int lens[3];
        int exp_ticks[3];
        int exp_max[3];
        int pat[6];
        int ec[6];
        int g;
        int k;
        int mx;
        int t;

        rst_n   = 1'b1;
        req     = '0;
        req_len = '0;
        enable  = 1'b0;
        model_reset();
        do_reset();

        // single job, len 3
        req = 4'b0001; req_len = 16'h0003; enable = 1'b1;
        step();
        chk("single_grant", 32'(grant), 32'd1);
        step(); step();
        chk("single_count2", 32'(count), 32'd2);
        step();
        chk("single_done", 32'(done), 32'd1);
        chk("single_grant_off", 32'(grant), 32'd0);
        req = '0;
        step(); step();

        // round robin with all requesters asking for one tick
        do_reset();
        req = 4'hF; req_len = 16'h1111; enable = 1'b1;
        k = 0; g = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (grant != 0) begin
                chk("rr_grant", 32'(grant), 32'd1 << (g % 4));
                g++;
            end
            if (done) begin
                chk("rr_done_id", 32'(done_id), 32'(k % 4));
                k++;
            end
        end
        chk("rr_jobs", 32'(k), 32'd5);
        req = '0;
        step(); step();

        // length clamping
        lens = '{0, 15, 9}; exp_ticks = '{1, 9, 9}; exp_max = '{0, 8, 8};
        for (int j = 0; j < 3; j++) begin
            req_len = 16'(lens[j]); req = 4'b0001; enable = 1'b1;
            step();
            g = 0; mx = 0; t = 0;
            while (!done && t < 30) begin
                if (grant[0]) g++;
                if (int'(count) > mx) mx = int'(count);
                step();
                t++;
            end
            chk("clamp_done", 32'(done), 32'd1);
            chk("clamp_ticks", 32'(g), 32'(exp_ticks[j]));
            chk("clamp_max", 32'(mx), 32'(exp_max[j]));
            req = '0;
            step(); step();
        end

        // enable gating with len 4
        do_reset();
        pat = '{1, 0, 0, 1, 1, 1}; ec = '{0, 1, 1, 1, 2, 3};
        req = 4'b0001; req_len = 16'h0004; enable = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            chk("gate_count", 32'(count), 32'(ec[i]));
            chk("gate_grant", 32'(grant), 32'd1);
            enable = (pat[i] != 0);
            step();
        end
        chk("gate_done", 32'(done), 32'd1);
        req = '0; enable = 1'b1;
        step(); step();

        // abort with a pending contender, then reset mid-run
        do_reset();
        req = 4'b0100; req_len = 16'h0900;
        step();
        chk("abort_grant2", 32'(grant), 32'd4);
        req = 4'b0110;
        t = 0;
        while (count != 4 && t < 20) begin
            step();
            t++;
        end
        chk("abort_reach4", 32'(count), 32'd4);
        req = 4'b0010;
        step();
        chk("abort_grant_off", 32'(grant), 32'd0);
        chk("abort_no_done", 32'(done), 32'd0);
        step();
        chk("abort_next_grant", 32'(grant), 32'd2);
        step(); step();
        do_reset();
        req = '0;
        step();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 15) == 0) req[b] = ~req[b];
            end
            if ($urandom_range(0, 3) == 0) req_len = 16'($urandom);
            enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) do_reset();
            else step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decade_count_scheduler.md
Name: decade_count_scheduler

Overview:
- Round-robin scheduler that shares one mod-10 (decade) tick counter among NUM_REQ requesters.
- Each requester asks for a timed slot of 1..9 counter ticks. The block grants the counter to one requester, sequences the count and signals completion.
- Sits between client logic and the decade counting datapath in the small-sequential library.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- IDW, 2, width of done_id; must satisfy 2**IDW >= NUM_REQ

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  NUM_REQ  per-requester request level; must be held until done or abort
- req_len  input  4*NUM_REQ  packed tick length per requester, slice i = bits [4i+3:4i]
- enable  input  1  tick enable; counter advances only when high
- grant  output  NUM_REQ  one-hot owner of the counter; all zero when unowned
- busy  output  1  high in RUN and DONE
- count  output  4  current tick count, always 0..9
- done  output  1  one-cycle completion pulse
- done_id  output  IDW  index of the finishing requester, valid while done=1

Behaviour:
- Reset (async, rst_n=0): state=IDLE, grant=0, busy=0, count=0, done=0, done_id=0. Round-robin pointer=NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, RUN, DONE.
- IDLE:
  - If req != 0, pick the first set bit searching upward from pointer+1 with wrap-around.
  - Latch its index and length len_q. Clamp the length: 0 becomes 1, values above 9 become 9.
  - Set grant one-hot, count=0, pointer=winner, and go to RUN on the next edge. Grant latency is 1 cycle from req.
- RUN:
  - On each cycle with enable=1: if count==len_q-1, set count to 0 and go to DONE; otherwise count increments.
  - Count never exceeds 9.
  - With enable held high, grant lasts exactly len_q cycles. enable=0 freezes count.
- DONE (exactly one cycle):
  - grant=0, done=1, done_id=latched index, count=0, busy=1.
  - Next state is always IDLE. Arbitration never occurs in DONE, so back-to-back jobs are separated by DONE plus the IDLE arbitration cycle.
- Abort: if the owner's req bit drops during RUN, the next edge gives grant=0, count=0, state=IDLE, with no done pulse. The pointer remains at the aborted index.
- Sampling rules:
  - req and req_len are sampled only in IDLE.
  - Changes to req_len during RUN are ignored.
  - Non-owner req bits in RUN and DONE are ignored, not lost; they are considered at the next IDLE.
- Simultaneous requests: round-robin order guarantees no starvation. Each requester wins at most once per NUM_REQ grants while others are pending.
- Outputs are registered. grant, busy, done and count change only on clk edges, or asynchronously on reset.
- Reset mid-RUN: everything returns to reset values immediately, and no done pulse is produced.

Decomposition:
- Shared package:
  - state encoding constants (IDLE, RUN, DONE)
  - MAX_TICK=9 and LEN_W=4
  - clamp rule for lengths (0 to 1, above 9 to 9)
- One natural sub-module, rr_pick: combinational round-robin priority selector. Inputs are req and pointer; outputs are a one-hot winner and its index.
- The counter and FSM stay in the top module.

Test Plan:
- Reset: rst_n=0 mid-stream -> grant=0, count=0, busy=0, done=0 immediately, without waiting for a clk edge.
- Single job: req=0001, len0=3, enable=1 -> grant=0001 the cycle after req; count 0,1,2; then done=1 with done_id=0; grant=0 on the 4th post-grant cycle.
- Round-robin: req=1111, all lens=1, held -> grant order 0,1,2,3,0; done_id follows the same order.
- Length clamping:
  - len=0 -> 1 tick.
  - len=15 -> count runs 0..8, then DONE. Count never shows 10..15.
  - len=9 -> max count 8.
- Enable gating: len=4, enable toggled 1,0,0,1,1,1 -> count 0,1,1,1,2,3, then DONE. Grant is held for 6 cycles.
- Abort and contention: requester 2 granted with len=9, req2 dropped at count=4 -> next edge grant=0, count=0, no done. Pending req1 is granted one IDLE cycle later.
